// File: rtl/alu_pkg.sv
// Shared definitions for the datapath ALU: opcode encodings and default width.
// The control unit imports this same package so both sides agree on the encodings.
package alu_pkg;

    localparam int ALU_DATA_WIDTH = 8;

    typedef logic [2:0] aluop_t;

    localparam aluop_t ALU_FWD = 3'b000;
    localparam aluop_t ALU_ADD = 3'b001;
    localparam aluop_t ALU_AND = 3'b010;
    localparam aluop_t ALU_OR  = 3'b011;

    // Any code with the top bit set is reserved; it yields a zero result.
    function automatic logic alu_is_reserved(aluop_t op);
        return op[2];
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational core of the ALU: opcode decode, the four function units
// and zero detect. Reserved opcodes produce a zero result.
module alu_comb
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] operand1_i,
    input  logic [DATA_WIDTH-1:0] operand2_i,
    input  logic [2:0]            aluop_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  zero_o
);

    aluop_t                op;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] and_res;
    logic [DATA_WIDTH-1:0] or_res;

    assign op = aluop_t'(aluop_i);

    // Carry-out is dropped: the sum wraps modulo 2^DATA_WIDTH.
    assign sum     = operand1_i + operand2_i;
    assign and_res = operand1_i & operand2_i;
    assign or_res  = operand1_i | operand2_i;

    always_comb begin
        result_o = '0;
        if (!alu_is_reserved(op)) begin
            case (op)
                ALU_FWD: result_o = operand2_i;
                ALU_ADD: result_o = sum;
                ALU_AND: result_o = and_res;
                ALU_OR:  result_o = or_res;
                default: result_o = '0;
            endcase
        end
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU of the lab CPU datapath: result feeds register-file
// write-back, zero flag feeds branch logic. One-cycle latency, synchronous reset.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = ALU_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] OPERAND1,
    input  logic [DATA_WIDTH-1:0] OPERAND2,
    input  logic [2:0]            ALUOP,
    output logic [DATA_WIDTH-1:0] OUTPUT,
    output logic                  ZERO
);

    logic [DATA_WIDTH-1:0] output_d;
    logic [DATA_WIDTH-1:0] output_q;
    logic                  zero_d;
    logic                  zero_q;

    alu_comb #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu_comb (
        .operand1_i (OPERAND1),
        .operand2_i (OPERAND2),
        .aluop_i    (ALUOP),
        .result_o   (output_d),
        .zero_o     (zero_d)
    );

    // Reset wins over the operation computed in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            output_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            output_q <= output_d;
            zero_q   <= zero_d;
        end
    end

    assign OUTPUT = output_q;
    assign ZERO   = zero_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: the driver pushes the expected registered result
// at each edge, a monitor on the falling edge pops and compares.
module tb_alu;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] OPERAND1;
    logic [7:0] OPERAND2;
    logic [2:0] ALUOP;
    logic [7:0] OUTPUT;
    logic       ZERO;

    typedef struct {
        logic [7:0] res;
        logic       z;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .ALUOP    (ALUOP),
        .OUTPUT   (OUTPUT),
        .ZERO     (ZERO)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(logic rst, int a, int b, int op, string tag);
        exp_t e;
        int   r;
        if (rst)          r = 0;
        else if (op == 0) r = b;
        else if (op == 1) r = (a + b) % 256;
        else if (op == 2) r = a & b;
        else if (op == 3) r = a | b;
        else              r = 0;
        e.res = 8'(r);
        e.z   = (r == 0);
        e.tag = tag;
        return e;
    endfunction

    task automatic apply(logic rst, logic [7:0] a, logic [7:0] b, logic [2:0] op, string tag);
        exp_t e;
        RESET    = rst;
        OPERAND1 = a;
        OPERAND2 = b;
        ALUOP    = op;
        e = model(rst, int'(a), int'(b), int'(op), tag);
        @(posedge CLK);
        exp_q.push_back(e);
        #1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (OUTPUT !== e.res) begin
                n_fail++;
                $display("FAIL %s OUTPUT: got %h expected %h", e.tag, OUTPUT, e.res);
            end
            n_checks++;
            if (ZERO !== e.z) begin
                n_fail++;
                $display("FAIL %s ZERO: got %b expected %b", e.tag, ZERO, e.z);
            end
        end
    end

    initial begin
        RESET    = 1'b0;
        OPERAND1 = 8'h00;
        OPERAND2 = 8'h00;
        ALUOP    = 3'b000;
        @(posedge CLK);
        #1;

        apply(1'b1, 8'h05, 8'h04, 3'b001, "reset0");
        apply(1'b1, 8'h05, 8'h04, 3'b001, "reset1");
        apply(1'b0, 8'h05, 8'h04, 3'b001, "post_reset_add");

        apply(1'b0, 8'h01, 8'h02, 3'b001, "add_1_2");
        apply(1'b0, 8'h05, 8'h02, 3'b001, "add_5_2");
        apply(1'b0, 8'h05, 8'h04, 3'b001, "add_5_4");
        apply(1'b0, 8'hFF, 8'h01, 3'b001, "add_wrap");

        apply(1'b0, 8'h05, 8'h04, 3'b010, "and_5_4");
        apply(1'b0, 8'h05, 8'h04, 3'b011, "or_5_4");
        apply(1'b0, 8'hF0, 8'h0A, 3'b010, "and_zero");
        apply(1'b0, 8'hA0, 8'h0A, 3'b011, "or_aa");

        apply(1'b0, 8'h05, 8'h04, 3'b000, "fwd_04");
        apply(1'b0, 8'hA0, 8'h04, 3'b000, "fwd_op1_chg");
        apply(1'b0, 8'hA0, 8'h0A, 3'b000, "fwd_op2_chg");

        for (int op = 4; op < 8; op++)
            apply(1'b0, 8'h05, 8'h04, 3'(op), "reserved");

        apply(1'b0, 8'h05, 8'h04, 3'b001, "mid_pre");
        apply(1'b1, 8'h05, 8'h04, 3'b001, "mid_reset");
        apply(1'b0, 8'h05, 8'h04, 3'b001, "mid_resume");

        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 15) == 0), 8'($urandom), 8'($urandom),
                  3'($urandom_range(0, 7)), "random");
        end

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(negedge CLK);
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
